dw_tap_sequencer: RTL and testbench
===================================

# dw_tap_sequencer

Sequencer for one 3x3 depthwise-convolution output pixel, built around a single shared instance of the signed fixed-point `Mult` datapath. It accepts a start command with a bias and streams TAPS pixel/weight pairs through `Mult`, one per cycle. It accumulates the `Mult` outputs on top of the bias and returns one saturated DATA_SIZE-bit result over a valid/ready handshake. It sits between the line-buffer/weight fetch logic and the output feature-map writer of the depthwise stage.

## Interface
- DATA_SIZE, 8: width of pixel, weight, bias, `Mult` operands/result and output.
- TAPS, 9: pairs consumed per output; must be ≥1.
- ACC_W, 16: signed accumulator width; must be ≥ DATA_SIZE + clog2(TAPS+1).
- clk  in  1  clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  command pulse; honoured only in IDLE.
- bias_in  in  DATA_SIZE  signed bias, latched when start is honoured.
- in_valid  in  1  pixel/weight pair present.
- in_ready  out  1  high exactly in LOAD.
- in_pixel  in  DATA_SIZE  signed activation.
- in_weight  in  DATA_SIZE  signed weight.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts result.
- out_data  out  DATA_SIZE  signed saturated result.
- sat_flag  out  1  result was clipped; qualified by out_valid.
- busy  out  1  state ≠ IDLE.

## Operation
- States: IDLE, LOAD, DRAIN, OUT.
- IDLE:
  - on start → LOAD.
  - acc ← sign-extended bias_in; tap_cnt ← 0; prod_v ← 0.
- LOAD:
  - in_ready=1.
  - Each in_valid&in_ready drives `Mult` combinationally: prod_q ← Mult(in_pixel, in_weight), prod_v ← 1, tap_cnt++.
  - Cycles without an accept set prod_v ← 0.
  - Whenever prod_v=1, acc ← acc + sign-extended prod_q.
  - Accept with tap_cnt = TAPS-1 → DRAIN.
- DRAIN (one cycle):
  - final = acc + prod_q (prod_v is 1 here).
  - out_data ← sat(final) to [-2^(DATA_SIZE-1), 2^(DATA_SIZE-1)-1].
  - sat_flag ← clipped; out_valid ← 1; → OUT.
- OUT:
  - Hold out_data/sat_flag/out_valid stable until out_valid&out_ready.
  - On that cycle → IDLE; out_valid ← 0.
- `Mult` operands are driven from in_pixel/in_weight only; `Mult` result is sampled only on accept cycles.
- start outside IDLE is ignored, with no effect on acc or bias.
- in_valid outside LOAD is ignored; no pair is consumed.

## Timing
- Reset values: state=IDLE, in_ready=0, out_valid=0, out_data=0, sat_flag=0, busy=0, acc=0, tap_cnt=0, prod_v=0.
- Start accepted in cycle c0:
  - in_ready is high from c1.
  - With in_valid held high, taps are accepted in c1..cTAPS.
  - DRAIN occurs in cTAPS+1.
  - out_valid rises in cTAPS+2 (c11 for TAPS=9).
- in_valid gaps stretch LOAD one cycle per gap; the result is unchanged.
- out_ready already high when out_valid rises: out_valid is high exactly one cycle; next start is honoured the following cycle (IDLE).
- Throughput: one result per TAPS+3 cycles.
- rst mid-operation (any state) returns immediately to the reset values. A partial accumulation is discarded and never emitted.
- The accumulator never overflows within the ACC_W rule; saturation is applied only at DRAIN.

## Structure
- Shared package `dw_pkg`:
  - DATA_SIZE/TAPS/ACC_W defaults
  - state encoding constants
  - saturate-to-DATA_SIZE function (reused by the pointwise stage)
- One `Mult` instance inside.
- No new sub-module: the FSM, counter and accumulator live in this block.

## Test plan
- Reset mid-LOAD after 4 taps, then a new command with bias=3 and 9 zero pixels → out_data=3, sat_flag=0; no stale result emitted.
- bias=5, 9 pairs with pixel=0, any weight, in_valid always high → out_valid at c11, out_data=5, sat_flag=0.
- bias=0, 9 pairs pixel=64/weight=64 with in_valid toggling 1,0,1,0… → out_data=sat(9·m), where m=Mult(64,64) sampled standalone; out_valid at c20.
- bias=127, 9 pairs with positive Mult result → out_data=127, sat_flag=1. Mirror case: bias=-128 with negative products → -128, sat_flag=1.
- out_ready held low 5 cycles after out_valid → out_data stable, busy=1, start pulses ignored. out_ready high → IDLE next cycle.
- start pulsed during LOAD with a different bias_in → result uses the original bias; tap count is unaffected.

Source files
------------

// File: rtl/dw_pkg.sv
// rtl/dw_pkg.sv - shared depthwise-stage constants, FSM encoding and saturation helper
package dw_pkg;

    localparam int DW_DATA_SIZE = 8;
    localparam int DW_TAPS      = 9;
    localparam int DW_ACC_W     = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_OUT   = 2'd3
    } dw_state_t;

    typedef struct packed {
        logic                    clipped;
        logic [DW_DATA_SIZE-1:0] value;
    } dw_sat_t;

    // Clamp a signed accumulator into the signed DATA_SIZE output range.
    function automatic dw_sat_t dw_saturate(input logic signed [DW_ACC_W-1:0] v);
        logic signed [DW_ACC_W-1:0] sat_max;
        logic signed [DW_ACC_W-1:0] sat_min;
        dw_sat_t r;
        sat_max = {{(DW_ACC_W-DW_DATA_SIZE+1){1'b0}}, {(DW_DATA_SIZE-1){1'b1}}};
        sat_min = {{(DW_ACC_W-DW_DATA_SIZE+1){1'b1}}, {(DW_DATA_SIZE-1){1'b0}}};
        if (v > sat_max) begin
            r.clipped = 1'b1;
            r.value   = sat_max[DW_DATA_SIZE-1:0];
        end else if (v < sat_min) begin
            r.clipped = 1'b1;
            r.value   = sat_min[DW_DATA_SIZE-1:0];
        end else begin
            r.clipped = 1'b0;
            r.value   = v[DW_DATA_SIZE-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/Mult.sv
// rtl/Mult.sv - signed Q1.(DATA_SIZE-1) fixed-point multiplier with saturating result
module Mult #(
    parameter int DATA_SIZE = 8
) (
    input  logic [DATA_SIZE-1:0] a,
    input  logic [DATA_SIZE-1:0] b,
    output logic [DATA_SIZE-1:0] p
);

    localparam int FRAC = DATA_SIZE - 1;
    localparam int PW   = 2 * DATA_SIZE;
    localparam logic signed [PW-1:0] PMAX = {{(PW-DATA_SIZE+1){1'b0}}, {(DATA_SIZE-1){1'b1}}};
    localparam logic signed [PW-1:0] PMIN = {{(PW-DATA_SIZE+1){1'b1}}, {(DATA_SIZE-1){1'b0}}};

    logic signed [PW-1:0] full;
    logic signed [PW-1:0] scaled;

    assign full   = $signed(a) * $signed(b);
    assign scaled = full >>> FRAC;

    // Only (-1.0)*(-1.0) can exceed the range; clamp it rather than wrap.
    always_comb begin
        p = scaled[DATA_SIZE-1:0];
        if (scaled > PMAX) begin
            p = PMAX[DATA_SIZE-1:0];
        end else if (scaled < PMIN) begin
            p = PMIN[DATA_SIZE-1:0];
        end
    end

endmodule

// File: rtl/dw_tap_sequencer.sv
// rtl/dw_tap_sequencer.sv - 3x3 depthwise tap sequencer around one shared Mult
module dw_tap_sequencer
    import dw_pkg::*;
#(
    parameter int DATA_SIZE = DW_DATA_SIZE,
    parameter int TAPS      = DW_TAPS,
    parameter int ACC_W     = DW_ACC_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [DATA_SIZE-1:0] bias_in,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATA_SIZE-1:0] in_pixel,
    input  logic [DATA_SIZE-1:0] in_weight,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_SIZE-1:0] out_data,
    output logic                 sat_flag,
    output logic                 busy
);

    localparam int CNT_W = $clog2(TAPS + 1);

    dw_state_t state, state_nxt;

    logic [CNT_W-1:0]        tap_cnt;
    logic signed [ACC_W-1:0] acc;
    logic [DATA_SIZE-1:0]    prod_q;
    logic                    prod_v;
    logic [DATA_SIZE-1:0]    mult_p;
    logic                    accept;
    logic                    last_tap;
    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W-1:0] final_sum;
    dw_sat_t                 sat_res;

    Mult #(.DATA_SIZE(DATA_SIZE)) u_mult (
        .a (in_pixel),
        .b (in_weight),
        .p (mult_p)
    );

    assign in_ready  = (state == ST_LOAD);
    assign busy      = (state != ST_IDLE);
    assign accept    = in_ready && in_valid;
    assign last_tap  = (tap_cnt == CNT_W'(TAPS - 1));
    assign prod_ext  = {{(ACC_W-DATA_SIZE){prod_q[DATA_SIZE-1]}}, prod_q};
    assign final_sum = acc + prod_ext;
    assign sat_res   = dw_saturate(final_sum);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start) state_nxt = ST_LOAD;
            ST_LOAD:  if (accept && last_tap) state_nxt = ST_DRAIN;
            ST_DRAIN: state_nxt = ST_OUT;
            ST_OUT:   if (out_ready) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // The product lands one cycle after its accept, so acc trails by one tap
    // and DRAIN folds in the final product.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc       <= '0;
            tap_cnt   <= '0;
            prod_q    <= '0;
            prod_v    <= 1'b0;
            out_data  <= '0;
            sat_flag  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    acc     <= {{(ACC_W-DATA_SIZE){bias_in[DATA_SIZE-1]}}, bias_in};
                    tap_cnt <= '0;
                    prod_v  <= 1'b0;
                end
                ST_LOAD: begin
                    if (prod_v) acc <= final_sum;
                    if (accept) begin
                        prod_q  <= mult_p;
                        prod_v  <= 1'b1;
                        tap_cnt <= tap_cnt + 1'b1;
                    end else begin
                        prod_v <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    out_data  <= sat_res.value;
                    sat_flag  <= sat_res.clipped;
                    out_valid <= 1'b1;
                end
                ST_OUT: begin
                    if (out_ready) out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dw_tap_sequencer.sv
// tb/tb_dw_tap_sequencer.sv - scoreboard bench for dw_tap_sequencer
module tb_dw_tap_sequencer;

    localparam int TAPS = 9;
    localparam int NO_MID = -999;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] bias_in;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_pixel;
    logic [7:0] in_weight;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       sat_flag;
    logic       busy;

    always #5 clk = ~clk;

    dw_tap_sequencer #(.DATA_SIZE(8), .TAPS(TAPS), .ACC_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .bias_in   (bias_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pixel  (in_pixel),
        .in_weight (in_weight),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .sat_flag  (sat_flag),
        .busy      (busy)
    );

    typedef struct {
        int data;
        int sat;
    } exp_t;

    exp_t sbq[$];
    int   tests = 0;
    int   fails = 0;
    int   n_pushed = 0;
    int   n_seen = 0;
    int   px[TAPS];
    int   wt[TAPS];

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int rnd8();
        logic [7:0] r;
        r = 8'($urandom);
        return int'($signed(r));
    endfunction

    // Q1.7 product: floor(a*b / 128), clamped to the 8-bit signed range.
    function automatic int mult_ref(input int a, input int b);
        int p;
        int q;
        p = a * b;
        q = p / 128;
        if (p < 0 && (p % 128) != 0) q = q - 1;
        if (q > 127) q = 127;
        if (q < -128) q = -128;
        return q;
    endfunction

    task automatic push_expected(input int bias);
        exp_t e;
        int   sum;
        sum = bias;
        for (int k = 0; k < TAPS; k++) sum += mult_ref(px[k], wt[k]);
        e.sat  = (sum > 127 || sum < -128) ? 1 : 0;
        e.data = (sum > 127) ? 127 : (sum < -128) ? -128 : sum;
        sbq.push_back(e);
        n_pushed++;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                n_seen++;
                if (sbq.size() == 0) begin
                    check("unexpected_result", 1, 0);
                end else begin
                    e = sbq.pop_front();
                    check("out_data", int'($signed(out_data)), e.data);
                    check("sat_flag", int'(sat_flag), e.sat);
                end
            end
        end
    end

    task automatic check_reset_vals(input string tag);
        check({tag, "_in_ready"}, int'(in_ready), 0);
        check({tag, "_out_valid"}, int'(out_valid), 0);
        check({tag, "_out_data"}, int'(out_data), 0);
        check({tag, "_sat_flag"}, int'(sat_flag), 0);
        check({tag, "_busy"}, int'(busy), 0);
    endtask

    // mode 0: in_valid always high; 1: toggling 1,0,1,0 starting in c0; 3: random
    task automatic run_cmd(input int bias, input int mode, input int hold,
                           input int exp_lat, input int mid_bias);
        int         cyc;
        int         taps;
        logic       acc_now;
        logic [7:0] held;
        push_expected(bias);
        @(posedge clk); #1;
        start     = 1'b1;
        bias_in   = 8'(bias);
        out_ready = (hold == 0);
        in_valid  = (mode != 3);
        in_pixel  = 8'(px[0]);
        in_weight = 8'(wt[0]);
        cyc  = 0;
        taps = 0;
        while (taps < TAPS && cyc < 200) begin
            acc_now = in_valid && in_ready;
            @(posedge clk); #1;
            cyc++;
            if (acc_now) taps++;
            if (mid_bias != NO_MID && cyc == 4) begin
                start   = 1'b1;
                bias_in = 8'(mid_bias);
            end else begin
                start = 1'b0;
            end
            if (mode == 0 && cyc == 1) check("in_ready_c1", int'(in_ready), 1);
            case (mode)
                0:       in_valid = 1'b1;
                1:       in_valid = (cyc % 2 == 0);
                default: in_valid = 1'($urandom_range(0, 1));
            endcase
            if (taps < TAPS) begin
                in_pixel  = 8'(px[taps]);
                in_weight = 8'(wt[taps]);
            end
        end
        in_valid = 1'b0;
        start    = 1'b0;
        while (!out_valid && cyc < 300) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (exp_lat > 0) check("out_valid_latency", cyc, exp_lat);
        else check("out_valid_seen", int'(out_valid), 1);
        if (hold > 0) begin
            held = out_data;
            for (int i = 0; i < hold; i++) begin
                start   = 1'b1;
                bias_in = ~bias_in;
                @(posedge clk); #1;
                check("hold_out_valid", int'(out_valid), 1);
                check("hold_out_data", int'(out_data), int'(held));
                check("hold_busy", int'(busy), 1);
            end
            start     = 1'b0;
            out_ready = 1'b1;
        end
        @(posedge clk); #1;
        check("post_hs_out_valid", int'(out_valid), 0);
        check("post_hs_busy", int'(busy), 0);
    endtask

    initial begin : stim
        rst = 1'b1; start = 1'b0; bias_in = '0; in_valid = 1'b0;
        in_pixel = '0; in_weight = '0; out_ready = 1'b0;
        #12;
        check_reset_vals("reset");
        rst = 1'b0;

        // Reset mid-LOAD after 4 accepted taps; the partial result must vanish.
        @(posedge clk); #1;
        start = 1'b1; bias_in = 8'd50; out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; in_valid = 1'b1; in_pixel = 8'd100; in_weight = 8'd100;
        repeat (4) begin @(posedge clk); #1; end
        rst = 1'b1;
        #2;
        check_reset_vals("rst_mid_load");
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < TAPS; k++) begin px[k] = 0; wt[k] = rnd8(); end
        run_cmd(3, 0, 0, 11, NO_MID);

        for (int k = 0; k < TAPS; k++) begin px[k] = 0; wt[k] = rnd8(); end
        run_cmd(5, 0, 0, 11, NO_MID);

        for (int k = 0; k < TAPS; k++) begin px[k] = 64; wt[k] = 64; end
        run_cmd(0, 1, 0, 20, NO_MID);

        for (int k = 0; k < TAPS; k++) begin
            px[k] = $urandom_range(16, 127); wt[k] = $urandom_range(16, 127);
        end
        run_cmd(127, 0, 0, 11, NO_MID);

        for (int k = 0; k < TAPS; k++) begin
            px[k] = $urandom_range(16, 127); wt[k] = -$urandom_range(16, 127);
        end
        run_cmd(-128, 0, 0, 11, NO_MID);

        for (int k = 0; k < TAPS; k++) begin px[k] = rnd8(); wt[k] = rnd8(); end
        run_cmd(rnd8(), 0, 5, 11, NO_MID);

        for (int k = 0; k < TAPS; k++) begin px[k] = rnd8(); wt[k] = rnd8(); end
        run_cmd(-7, 0, 0, 11, 90);

        for (int n = 0; n < 20; n++) begin
            for (int k = 0; k < TAPS; k++) begin px[k] = rnd8(); wt[k] = rnd8(); end
            run_cmd(rnd8(), 3, int'($urandom_range(0, 3)), 0, NO_MID);
        end

        repeat (5) @(posedge clk);
        #1;
        check("scoreboard_empty", sbq.size(), 0);
        check("result_count", n_seen, n_pushed);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
